spdt_debounce_sync: RTL
=======================

// Module: spdt_debounce_sync
// PURPOSE
//  Clocked conditioner for a single-pole double-throw push switch (two contacts, active-low).
//  Synchronises both contacts and filters contact bounce with a stability counter.
//  Produces a clean level plus single-cycle rise/fall pulses and a contact-fault flag.
//  Sits directly upstream of the switch-event ripple counter; rise_o is that counter's count input.
// PARAMETERS
//  STABLE_CYCLES  16  consecutive clk edges a decoded request must persist before level_o changes (>=1)
//  CNT_W          $clog2(STABLE_CYCLES+1)  stability counter width (derived, do not override)
// PORTS
//  clk      in   1  single clock; all state updates on posedge clk
//  rst      in   1  reset, asynchronous, active-high
//  a        in   1  contact A, async, active-low; low = request level 0 (released)
//  b        in   1  contact B, async, active-low; low = request level 1 (pressed)
//  level_o  out  1  debounced switch level
//  rise_o   out  1  one-cycle pulse on the edge level_o goes 0->1
//  fall_o   out  1  one-cycle pulse on the edge level_o goes 1->0
//  fault_o  out  1  registered; high while synchronised a and b are both low
// BEHAVIOUR
//  Reset (async assert, released on clk): sync flops=1, state=S_LOW, cnt=0,
//   level_o=0, rise_o=0, fall_o=0, fault_o=0.
//  Sync: a and b each pass 2 flops -> a_s, b_s. A change before edge k is visible to the FSM at edge k+2.
//  Decode {a_s,b_s}: 01=REQ_LO, 10=REQ_HI, 11=TRANSIT (between throws), 00=FAULT.
//  FSM states: S_LOW, S_CHK_HI, S_HIGH, S_CHK_LO.
//   S_LOW:    REQ_HI -> S_CHK_HI, cnt=1; all other decodes: stay.
//   S_CHK_HI: REQ_HI -> cnt+1; on the edge cnt would reach STABLE_CYCLES -> S_HIGH.
//             REQ_LO -> S_LOW, cnt=0 (bounce rejected).
//             TRANSIT -> stay, cnt=0 (restart count).
//             FAULT -> stay, cnt held.
//   S_HIGH / S_CHK_LO: mirror images (REQ_LO starts the check; REQ_HI aborts to S_HIGH).
//  STABLE_CYCLES=1: the first REQ_HI edge in S_LOW goes directly to S_HIGH (no S_CHK_HI).
//  level_o is registered: 1 in S_HIGH and S_CHK_LO, 0 otherwise.
//  rise_o/fall_o are high exactly one cycle, on the same edge level_o changes. Never both high.
//  Latency: input held steady from before edge k -> level_o changes at edge k+1+STABLE_CYCLES.
//  fault_o = registered (a_s==0 && b_s==0). No state change while FAULT; resumes when FAULT clears.
//  cnt saturates logic: never exceeds STABLE_CYCLES; no wrap.
//  rst mid-check: immediate return to reset values; no pulse is emitted.
//  Re-entry: a fresh REQ_HI after an aborted check restarts cnt at 1.
// STRUCTURE
//  Shared package/header sw_cond_pkg: FSM state encodings (S_LOW..S_CHK_LO) and decode codes
//   (REQ_LO, REQ_HI, TRANSIT, FAULT).
//  Sub-module sync2 (2-flop synchroniser, reset value parameterised, here 1): instantiated for a and for b.
//  Top: decode, FSM + counter, output registers.
// TESTING (STABLE_CYCLES=4 unless noted)
//  1 Reset: rst=1 with a=0,b=1 -> level_o=0, rise_o=fall_o=fault_o=0; hold 10 cycles after release, no pulse.
//  2 Clean press: a=1,b=0 from before edge k, held -> level_o=1 and rise_o=1 at edge k+5;
//    rise_o=0 at edge k+6.
//  3 Bounce: b toggles 0/1 every 2 cycles for 20 cycles, then held 0 -> no rise_o during toggling;
//    single rise_o 5 edges after the final stable sample.
//  4 Release: from level_o=1, a=0,b=1 held -> fall_o single pulse and level_o=0 five edges later.
//    Check STABLE_CYCLES=1 gives 2 edges.
//  5 Fault: a=0,b=0 for 8 cycles during S_CHK_HI -> fault_o=1 two edges after the change,
//    level_o unchanged, cnt held; then a=1 -> check resumes, rise_o after the remaining count.
//  6 Reset mid-check: rst pulse while cnt=3 in S_CHK_HI -> level_o=0, no rise_o.
//    After release with b still low, full 4-cycle recount before rise_o.

Source files
------------

// File: rtl/sw_cond_pkg.sv
// Shared definitions for the switch conditioning blocks.
//  state_t : debounce FSM states (settled low/high plus the two "checking" states)
//  dec_t   : decode of the synchronised contact pair {a_s, b_s}
//  decode(): maps the synchronised contacts onto dec_t
package sw_cond_pkg;

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_CHK_HI = 2'd1,
    S_HIGH   = 2'd2,
    S_CHK_LO = 2'd3
  } state_t;

  // Contacts are active-low: a low asks for level 0, b low asks for level 1.
  typedef enum logic [1:0] {
    FAULT   = 2'b00,  // both throws closed at once: physically impossible, hold everything
    REQ_LO  = 2'b01,
    REQ_HI  = 2'b10,
    TRANSIT = 2'b11   // lever between throws
  } dec_t;

  function automatic dec_t decode(input logic a_s, input logic b_s);
    return dec_t'({a_s, b_s});
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous input.
//  clk   : destination clock
//  rst   : asynchronous active-high reset, both flops load RST_VAL
//  d     : asynchronous input
//  q     : synchronised output (two clk edges of latency)
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/spdt_debounce_sync.sv
// Debouncer for a single-pole double-throw push switch with active-low contacts.
// Both contacts are synchronised, decoded into a request, and a request must
// persist for STABLE_CYCLES consecutive edges before the output level moves.
//  clk     : single clock
//  rst     : asynchronous active-high reset
//  a       : contact A (low = released request)
//  b       : contact B (low = pressed request)
//  level_o : debounced level
//  rise_o  : one-cycle pulse when level_o goes 0->1
//  fall_o  : one-cycle pulse when level_o goes 1->0
//  fault_o : registered flag, high while both synchronised contacts are low
module spdt_debounce_sync
  import sw_cond_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic fault_o
);

  // A single-cycle filter skips the checking states entirely.
  localparam bit ONE_CYCLE = (STABLE_CYCLES == 1);
  localparam logic [CNT_W:0] STABLE_LIM = (CNT_W + 1)'(STABLE_CYCLES);

  logic a_s;
  logic b_s;
  dec_t dec;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W:0]   cnt_inc;

  sync2 #(.RST_VAL(1'b1)) u_sync_a (.clk(clk), .rst(rst), .d(a), .q(a_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_b (.clk(clk), .rst(rst), .d(b), .q(b_s));

  assign dec = decode(a_s, b_s);

  // One extra bit so the "would reach the limit" test cannot wrap.
  assign cnt_inc = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_LOW;
      cnt_reg   <= '0;
      level_o   <= 1'b0;
      rise_o    <= 1'b0;
      fall_o    <= 1'b0;
      fault_o   <= 1'b0;
    end else begin
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
      fault_o <= (dec == FAULT);

      case (state_reg)
        S_LOW: begin
          if (dec == REQ_HI) begin
            if (ONE_CYCLE) begin
              state_reg <= S_HIGH;
              cnt_reg   <= '0;
              level_o   <= 1'b1;
              rise_o    <= 1'b1;
            end else begin
              state_reg <= S_CHK_HI;
              cnt_reg   <= CNT_W'(1);
            end
          end
        end

        S_CHK_HI: begin
          case (dec)
            REQ_HI: begin
              if (cnt_inc >= STABLE_LIM) begin
                state_reg <= S_HIGH;
                cnt_reg   <= '0;
                level_o   <= 1'b1;
                rise_o    <= 1'b1;
              end else begin
                cnt_reg <= cnt_inc[CNT_W-1:0];
              end
            end
            REQ_LO: begin
              state_reg <= S_LOW;
              cnt_reg   <= '0;
            end
            TRANSIT: cnt_reg <= '0;
            default: ;  // FAULT: freeze the count until the contacts make sense again
          endcase
        end

        S_HIGH: begin
          if (dec == REQ_LO) begin
            if (ONE_CYCLE) begin
              state_reg <= S_LOW;
              cnt_reg   <= '0;
              level_o   <= 1'b0;
              fall_o    <= 1'b1;
            end else begin
              state_reg <= S_CHK_LO;
              cnt_reg   <= CNT_W'(1);
            end
          end
        end

        S_CHK_LO: begin
          case (dec)
            REQ_LO: begin
              if (cnt_inc >= STABLE_LIM) begin
                state_reg <= S_LOW;
                cnt_reg   <= '0;
                level_o   <= 1'b0;
                fall_o    <= 1'b1;
              end else begin
                cnt_reg <= cnt_inc[CNT_W-1:0];
              end
            end
            REQ_HI: begin
              state_reg <= S_HIGH;
              cnt_reg   <= '0;
            end
            TRANSIT: cnt_reg <= '0;
            default: ;
          endcase
        end

        default: begin
          state_reg <= S_LOW;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule
